// File: rtl/pdn_rail_sequencer.sv
// Power-up sequencer for the VDD rail switches. A round-robin scheduler lets
// at most MAX_RAMPS rails be in their settling window at the same time.

module pdn_rail_lane #(
  parameter int RAMP_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic grant,
  output logic rail_en,
  output logic rail_good,
  output logic ramping,
  output logic waiting
);
  localparam int CW = $clog2(RAMP_CYCLES);

  typedef enum logic [1:0] {S_OFF, S_WAIT, S_RAMP, S_ON} st_t;

  st_t           st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= S_OFF;
      cnt <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Dropping the request wins over any grant or ramp progress.
  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      S_OFF:  if (req) st_nxt = S_WAIT;
      S_WAIT: if (!req) st_nxt = S_OFF;
              else if (grant) begin
                st_nxt  = S_RAMP;
                cnt_nxt = CW'(RAMP_CYCLES - 1);
              end
      S_RAMP: if (!req) st_nxt = S_OFF;
              else if (cnt == '0) st_nxt = S_ON;
              else cnt_nxt = cnt - 1'b1;
      S_ON:   if (!req) st_nxt = S_OFF;
      default: st_nxt = S_OFF;
    endcase
  end

  assign rail_en   = (st == S_RAMP) || (st == S_ON);
  assign rail_good = (st == S_ON);
  assign ramping   = (st == S_RAMP);
  assign waiting   = (st == S_WAIT);
endmodule

module pdn_rail_sequencer #(
  parameter int N_RAILS     = 8,
  parameter int RAMP_CYCLES = 16,
  parameter int MAX_RAMPS   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_RAILS-1:0] req_on,
  output logic [N_RAILS-1:0] rail_en,
  output logic [N_RAILS-1:0] rail_good,
  output logic [N_RAILS-1:0] ramping,
  output logic               busy,
  output logic               all_good
);
  localparam int PW = $clog2(N_RAILS);

  logic [N_RAILS-1:0] waiting, cand, gnt;
  logic [PW-1:0]      ptr, gidx;
  logic               found;
  int                 active, idx;

  for (genvar i = 0; i < N_RAILS; i++) begin : g_lane
    pdn_rail_lane #(.RAMP_CYCLES(RAMP_CYCLES)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .req       (req_on[i]),
      .grant     (gnt[i]),
      .rail_en   (rail_en[i]),
      .rail_good (rail_good[i]),
      .ramping   (ramping[i]),
      .waiting   (waiting[i])
    );
  end

  assign cand = waiting & req_on;

  // Slot count comes from registered state, so a rail leaving RAMP frees
  // its slot one edge later.
  always_comb begin
    active = 0;
    for (int i = 0; i < N_RAILS; i++) active = active + int'(ramping[i]);
  end

  always_comb begin
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (active < MAX_RAMPS) begin
      for (int k = 0; k < N_RAILS; k++) begin
        idx = (int'(ptr) + k) % N_RAILS;
        if (!found && cand[idx]) begin
          found    = 1'b1;
          gidx     = PW'(idx);
          gnt[idx] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else if (found) ptr <= (int'(gidx) == N_RAILS - 1) ? '0 : gidx + 1'b1;
  end

  assign busy     = |(waiting | ramping);
  assign all_good = (rail_good == req_on) && !busy;
endmodule
